alu_op_sequencer: RTL and testbench

//  Initiator side of the 8-bit ALU port. Accepts multi-byte AND/OR/ADD/SUB requests on a valid/ready channel.

---
 rtl/alu_op_sequencer_pkg.sv | 42 ++++
 rtl/alu_op_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: request opcodes, ALU control
// encodings, FSM state codes and the opcode-to-control mapping.
package alu_op_sequencer_pkg;

   // Request opcodes on req_op
   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   // ALU control encodings: [1:0] selects the operation, [2] selects subtract
   localparam logic [3:0] CTRL_AND = 4'b0000;
   localparam logic [3:0] CTRL_OR  = 4'b0001;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CTRL_SUB = 4'b0110;

   // FSM state codes, also visible on the dbg_state port
   localparam logic [2:0] ST_IDLE        = 3'd0;
   localparam logic [2:0] ST_ISSUE       = 3'd1;
   localparam logic [2:0] ST_CAPTURE     = 3'd2;
   localparam logic [2:0] ST_FIX_ISSUE   = 3'd3;
   localparam logic [2:0] ST_FIX_CAPTURE = 3'd4;
   localparam logic [2:0] ST_RESP        = 3'd5;

   // Map a request opcode onto the ALU control word
   function automatic logic [3:0] op_to_ctrl(input logic [1:0] op);
      logic [3:0] ctrl;
      case (op)
         OP_AND:  ctrl = CTRL_AND;
         OP_OR:   ctrl = CTRL_OR;
         OP_ADD:  ctrl = CTRL_ADD;
         default: ctrl = CTRL_SUB;
      endcase
      return ctrl;
   endfunction

   // ADD and SUB carry a chain between bytes; AND and OR do not
   function automatic logic op_is_arith(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Initiator for an 8-bit ALU. Breaks a NBYTES-wide AND/OR/ADD/SUB request into
// byte passes, repairs the carry/borrow chain with +1/-1 correction passes, and
// returns the wide result on a valid/ready response channel.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is high only in IDLE. resp_valid, once high, stays
// high with resp_result/resp_carry/resp_zero frozen until resp_ready is seen.
//
// ALU timing: alu_a/alu_b/alu_control are registers loaded on the edge that
// enters ISSUE/FIX_ISSUE. The ALU registers them at the end of that cycle and
// presents alu_result/alu_overflow during the following CAPTURE cycle, which
// is sampled at the end of CAPTURE. The response registers are loaded on the
// first RESP cycle, so resp_valid rises 2P+1 edges after the accept edge for
// P byte passes (including corrections).
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int NBYTES = 2,
   localparam int W = 8 * NBYTES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_op,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [W-1:0] resp_result,
   output logic         resp_carry,
   output logic         resp_zero,
   output logic [7:0]   alu_a,
   output logic [7:0]   alu_b,
   output logic [3:0]   alu_control,
   input  logic [7:0]   alu_result,
   input  logic         alu_overflow,
   output logic [2:0]   dbg_state
);

   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic [2:0]    state;
   logic [1:0]    op_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  res_q;
   logic          carry_q;
   logic          craw_q;
   logic [IW-1:0] idx;

   logic [7:0]    alu_a_q;
   logic [7:0]    alu_b_q;
   logic [3:0]    alu_ctrl_q;

   logic          resp_valid_q;
   logic [W-1:0]  resp_result_q;
   logic          resp_carry_q;
   logic          resp_zero_q;

   // Combinational helpers for byte selection and the correction decision
   logic [IW+2:0] sh_cur;
   logic [IW+2:0] sh_nxt;
   logic [W-1:0]  byte_mask;
   logic [W-1:0]  res_next;
   logic [7:0]    a_nbyte;
   logic [7:0]    b_nbyte;
   logic          need_fix;
   logic          last_byte;
   logic          pass_carry;
   logic          fix_carry;

   assign sh_cur = {idx, 3'b000};
   assign sh_nxt = {idx + IW'(1), 3'b000};

   // Byte merge for the captured result, next-byte operand select and the
   // carry/borrow bookkeeping used by CAPTURE and FIX_CAPTURE
   always_comb begin
      byte_mask  = W'(8'hFF) << sh_cur;
      res_next   = (res_q & ~byte_mask) | (W'(alu_result) << sh_cur);
      a_nbyte    = 8'(a_q >> sh_nxt);
      b_nbyte    = 8'(b_q >> sh_nxt);
      last_byte  = (idx == IW'(NBYTES - 1));
      // carry_q still holds the chain value coming out of byte idx-1 here
      need_fix   = (idx != '0) &&
                   (((op_q == OP_ADD) && carry_q) ||
                    ((op_q == OP_SUB) && !carry_q));
      pass_carry = op_is_arith(op_q) ? alu_overflow : 1'b0;
      // ADD: carry out if either the raw add or the +1 overflowed.
      // SUB: no borrow only if neither the raw subtract nor the -1 borrowed.
      fix_carry  = (op_q == OP_ADD) ? (craw_q | alu_overflow)
                                    : (craw_q & alu_overflow);
   end

   // Main sequencer FSM: accept, byte passes, corrections, response
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         op_q          <= OP_AND;
         a_q           <= '0;
         b_q           <= '0;
         res_q         <= '0;
         carry_q       <= 1'b0;
         craw_q        <= 1'b0;
         idx           <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_ctrl_q    <= '0;
         resp_valid_q  <= 1'b0;
         resp_result_q <= '0;
         resp_carry_q  <= 1'b0;
         resp_zero_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q       <= req_op;
                  a_q        <= req_a;
                  b_q        <= req_b;
                  res_q      <= '0;
                  idx        <= '0;
                  carry_q    <= (req_op == OP_SUB);
                  alu_a_q    <= req_a[7:0];
                  alu_b_q    <= req_b[7:0];
                  alu_ctrl_q <= op_to_ctrl(req_op);
                  state      <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               state <= ST_CAPTURE;
            end

            ST_CAPTURE: begin
               res_q  <= res_next;
               craw_q <= alu_overflow;
               if (need_fix) begin
                  // Re-run the byte just produced with +1 (ADD) or -1 (SUB);
                  // alu_control already holds the op's control word
                  alu_a_q <= alu_result;
                  alu_b_q <= 8'h01;
                  state   <= ST_FIX_ISSUE;
               end else begin
                  carry_q <= pass_carry;
                  if (!last_byte) begin
                     idx     <= idx + IW'(1);
                     alu_a_q <= a_nbyte;
                     alu_b_q <= b_nbyte;
                     state   <= ST_ISSUE;
                  end else begin
                     state <= ST_RESP;
                  end
               end
            end

            ST_FIX_ISSUE: begin
               state <= ST_FIX_CAPTURE;
            end

            ST_FIX_CAPTURE: begin
               res_q   <= res_next;
               carry_q <= fix_carry;
               if (!last_byte) begin
                  idx     <= idx + IW'(1);
                  alu_a_q <= a_nbyte;
                  alu_b_q <= b_nbyte;
                  state   <= ST_ISSUE;
               end else begin
                  state <= ST_RESP;
               end
            end

            ST_RESP: begin
               if (!resp_valid_q) begin
                  resp_valid_q  <= 1'b1;
                  resp_result_q <= res_q;
                  resp_carry_q  <= carry_q;
                  resp_zero_q   <= (res_q == '0);
               end else if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state        <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready   = (state == ST_IDLE);
   assign resp_valid  = resp_valid_q;
   assign resp_result = resp_result_q;
   assign resp_carry  = resp_carry_q;
   assign resp_zero   = resp_zero_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_control = alu_ctrl_q;
   assign dbg_state   = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer (NBYTES=2) paired with a behavioural 8-bit ALU.
// Directed scenarios followed by randomized requests, each checked against
// a wide-arithmetic reference model.
module tb_alu_op_sequencer;

   localparam int NB = 2;
   localparam int W  = 8 * NB;

   logic         clk;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_op;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic         resp_valid;
   logic         resp_ready;
   logic [W-1:0] resp_result;
   logic         resp_carry;
   logic         resp_zero;
   logic [7:0]   alu_a;
   logic [7:0]   alu_b;
   logic [3:0]   alu_control;
   logic [7:0]   alu_result;
   logic         alu_overflow;
   logic [2:0]   dbg_state;

   int n_vec = 0;
   int n_err = 0;

   alu_op_sequencer #(.NBYTES(NB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_a        (req_a),
      .req_b        (req_b),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_result  (resp_result),
      .resp_carry   (resp_carry),
      .resp_zero    (resp_zero),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_control  (alu_control),
      .alu_result   (alu_result),
      .alu_overflow (alu_overflow),
      .dbg_state    (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: registers its inputs, result/carry follow combinationally
   logic [7:0] alu_ra;
   logic [7:0] alu_rb;
   logic [3:0] alu_rc;
   logic [8:0] alu_sum;

   always @(posedge clk) begin
      alu_ra <= alu_a;
      alu_rb <= alu_b;
      alu_rc <= alu_control;
   end

   always_comb begin
      alu_sum = '0;
      case (alu_rc)
         4'b0000: alu_sum = {1'b0, alu_ra & alu_rb};
         4'b0001: alu_sum = {1'b0, alu_ra | alu_rb};
         4'b0010: alu_sum = {1'b0, alu_ra} + {1'b0, alu_rb};
         4'b0110: alu_sum = {1'b0, alu_ra} + {1'b0, ~alu_rb} + 9'd1;
         default: alu_sum = '0;
      endcase
   end

   assign alu_result   = alu_sum[7:0];
   assign alu_overflow = alu_sum[8];

   // Reference model: {carry, result} from plain wide arithmetic
   function automatic logic [W:0] ref_calc(input logic [1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [W:0] r;
      case (op)
         2'b00:   r = {1'b0, a & b};
         2'b01:   r = {1'b0, a | b};
         2'b10:   r = {1'b0, a} + {1'b0, b};
         default: r = {(a >= b), a - b};
      endcase
      return r;
   endfunction

   // Reference pass count: one pass per byte plus one for every byte above
   // byte 0 that receives a carry (ADD) or a borrow (SUB) from the bytes below
   function automatic int ref_passes(input logic [1:0] op,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b);
      int p;
      int m;
      int la;
      int lb;
      p = NB;
      for (int i = 1; i < NB; i++) begin
         m  = 1 << (8 * i);
         la = int'(a) % m;
         lb = int'(b) % m;
         if ((op == 2'b10) && (la + lb >= m)) p++;
         if ((op == 2'b11) && (la < lb)) p++;
      end
      return p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with req_ready seen high
   task automatic wait_ready();
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_wait", 32'(req_ready), 32'd1);
   endtask

   // Drive one request and return at the negedge right after the accept edge
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      wait_ready();
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_op    = 2'($urandom_range(0, 3));
      req_a     = W'($urandom);
      req_b     = W'($urandom);
   endtask

   // Called at the negedge right after the accept edge. Measures latency,
   // checks the response, holds backpressure for bp cycles and, if hs is set,
   // completes the handshake.
   task automatic collect(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int bp, input bit hs);
      logic [W:0]   exp;
      int           p;
      int           k;
      logic [W-1:0] s_res;
      logic         s_c;
      logic         s_z;
      logic [7:0]   s_a;
      logic [7:0]   s_b;
      logic [3:0]   s_ctl;
      exp = ref_calc(op, a, b);
      p   = ref_passes(op, a, b);
      k   = 0;
      while (resp_valid !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("latency_edges", 32'(k), 32'(2 * p + 1));
      chk("resp_result", 32'(resp_result), 32'(exp[W-1:0]));
      chk("resp_carry", 32'(resp_carry), 32'(exp[W]));
      chk("resp_zero", 32'(resp_zero), 32'(exp[W-1:0] == '0));
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      s_res = resp_result;
      s_c   = resp_carry;
      s_z   = resp_zero;
      s_a   = alu_a;
      s_b   = alu_b;
      s_ctl = alu_control;
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(resp_valid), 32'd1);
         chk("bp_result", 32'(resp_result), 32'(s_res));
         chk("bp_carry", 32'(resp_carry), 32'(s_c));
         chk("bp_zero", 32'(resp_zero), 32'(s_z));
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_alu", 32'({alu_a, alu_b, alu_control}), 32'({s_a, s_b, s_ctl}));
      end
      if (hs) begin
         resp_ready = 1'b1;
         @(negedge clk);
         resp_ready = 1'b0;
         chk("hs_valid_drop", 32'(resp_valid), 32'd0);
         chk("hs_req_ready", 32'(req_ready), 32'd1);
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int bp);
      issue(op, a, b);
      collect(op, a, b, bp, 1'b1);
   endtask

   // Directed and random stimulus
   initial begin
      logic [1:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_op     = 2'b00;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_alu_control", 32'(alu_control), 32'd0);
      chk("rst_resp_result", 32'(resp_result), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset in the middle of an ADD
      issue(2'b10, 16'h00FF, 16'h0001);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst_alu_control", 32'(alu_control), 32'd0);
      chk("mid_rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
      chk("mid_rst_resp", 32'({resp_result, resp_carry, resp_zero}), 32'd0);
      repeat (8) @(negedge clk);
      chk("mid_rst_no_stale_resp", 32'(resp_valid), 32'd0);
      run_op(2'b10, 16'h1234, 16'h0FCD, 0);

      // Directed cases
      run_op(2'b00, 16'hF0F0, 16'h3C3C, 0);
      run_op(2'b10, 16'h00FF, 16'h0001, 0);
      run_op(2'b10, 16'hFFFF, 16'h0001, 0);
      run_op(2'b11, 16'h0100, 16'h0001, 0);
      run_op(2'b11, 16'h0000, 16'h0001, 0);
      run_op(2'b01, 16'h0000, 16'h0000, 0);
      run_op(2'b11, 16'h1234, 16'h1234, 0);

      // Backpressure, then a back-to-back request queued during the handshake
      issue(2'b11, 16'h8001, 16'h0102);
      collect(2'b11, 16'h8001, 16'h0102, 4, 1'b0);
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      req_op     = 2'b01;
      req_a      = 16'h1200;
      req_b      = 16'h0034;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("b2b_resp_drop", 32'(resp_valid), 32'd0);
      chk("b2b_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b_accepted", 32'(req_ready), 32'd0);
      collect(2'b01, 16'h1200, 16'h0034, 0, 1'b1);

      // Randomized requests, biased toward carry/borrow boundaries
      for (int n = 0; n < 24; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = W'($urandom);
         rb  = W'($urandom);
         if ($urandom_range(0, 3) == 0) ra[7:0] = 8'hFF;
         if ($urandom_range(0, 3) == 0) rb[7:0] = 8'h00;
         run_op(rop, ra, rb, $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
